// File: rtl/led_matrix_scanner_pkg.sv
// Shared definitions for the LED matrix scanner: FSM encoding, index-width
// helper and the blanked pin levels.
package led_matrix_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  localparam int MAX_DIM = 16;

  // Cathodes are active-low, anodes active-high: blank means no LED can light.
  localparam logic [MAX_DIM-1:0] BLANK_CATHODE = '1;
  localparam logic [MAX_DIM-1:0] BLANK_ANODE   = '0;

  function automatic int idx_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_row_counter.sv
// Combined dwell + row counter; holds at zero while not running and flags
// the final dwell cycle of the final row.
module scan_row_counter #(
  parameter int ROWS  = 8,
  parameter int DWELL = 1,
  localparam int RW   = $clog2(ROWS),
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [DW-1:0] dwell;
  logic          end_dwell;

  assign end_dwell = (dwell == DW'(DWELL - 1));
  assign last      = run && end_dwell && (row == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      dwell <= '0;
    end else if (!run) begin
      row   <= '0;
      dwell <= '0;
    end else if (end_dwell) begin
      dwell <= '0;
      row   <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Snapshots a flat LED frame on request and scans it row by row onto the
// matrix pins, with optional continuous rescan and single-LED blinking.
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL        = 1,
  parameter int BLINK_FRAMES = 4,
  parameter int CONTINUOUS   = 0
) (
  input  logic                          in_clka,
  input  logic                          in_restart_n,
  input  logic                          in_start,
  input  logic [ROWS*COLS-1:0]          in_led_array_flat,
  input  logic                          in_blink_en,
  input  logic [idx_width(ROWS,COLS)-1:0] in_blink_index,
  output logic [ROWS-1:0]               out_row_cathode,
  output logic [COLS-1:0]               out_column_anode,
  output logic                          out_busy,
  output logic                          out_scan_done
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  scan_state_t   state, state_nxt;
  logic          load;
  logic [N-1:0]  snapshot, snap_nxt, blink_mask;
  logic [RW-1:0] row;
  logic          last;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_phase, blink_phase_nxt;

  scan_row_counter #(.ROWS(ROWS), .DWELL(DWELL)) u_cnt (
    .clk   (in_clka),
    .rst_n (in_restart_n),
    .run   (state == ST_SCAN),
    .row   (row),
    .last  (last)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: if (in_start) begin
        state_nxt = ST_SCAN;
        load      = 1'b1;
      end
      ST_SCAN: if (last) state_nxt = ST_DONE;
      ST_DONE: begin
        if (CONTINUOUS != 0) begin
          state_nxt = ST_SCAN;
          load      = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A snapshot taken in DONE must see the phase after this frame is counted.
  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    if (!in_blink_en) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b1;
    end else if (state == ST_DONE) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end
  end

  // Shifting past the top bit yields zero, so out-of-range indices mask nothing.
  assign blink_mask = (in_blink_en && !blink_phase_nxt)
                      ? ({{(N-1){1'b0}}, 1'b1} << in_blink_index) : '0;
  assign snap_nxt   = in_led_array_flat & ~blink_mask;

  always_ff @(posedge in_clka or negedge in_restart_n) begin
    if (!in_restart_n) begin
      state       <= ST_IDLE;
      snapshot    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      state       <= state_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      if (load) snapshot <= snap_nxt;
    end
  end

  always_comb begin
    out_row_cathode  = BLANK_CATHODE[ROWS-1:0];
    out_column_anode = BLANK_ANODE[COLS-1:0];
    if (state == ST_SCAN) begin
      out_row_cathode[row] = 1'b0;
      out_column_anode     = snapshot[row*COLS +: COLS];
    end
  end

  assign out_busy      = (state == ST_SCAN);
  assign out_scan_done = (state == ST_DONE);

endmodule
